// File: rtl/captura_adc_if.sv
// captura_adc_if: ADC serial bus plus sample-output bundle.
// master = capture block (drives cs/sclk/uk/datolisto), slave = ADC/filter side.
interface captura_adc_if #(
  parameter int N = 12
);
  logic         habilitar;
  logic         sdata;
  logic         cs;
  logic         sclk;
  logic [N-1:0] uk;
  logic         datolisto;

  modport master (
    input  habilitar,
    input  sdata,
    output cs,
    output sclk,
    output uk,
    output datolisto
  );

  modport slave (
    output habilitar,
    output sdata,
    input  cs,
    input  sclk,
    input  uk,
    input  datolisto
  );
endinterface

// File: rtl/captura_adc.sv
// captura_adc: periodic 16-clock serial capture from a 12-bit ADC, converted
// to left-aligned two's complement. Ports: clk, reset (sync, high), bus (master).
module captura_adc #(
  parameter int N          = 12,
  parameter int SCLK_DIV   = 4,
  parameter int SAMPLE_DIV = 2000
) (
  input  logic clk,
  input  logic reset,
  captura_adc_if.master bus
);

  localparam int TW = $clog2(SAMPLE_DIV);
  localparam int HW = $clog2(SCLK_DIV + 1);

  typedef enum logic [1:0] {
    REPOSO,
    CAPTURA,
    FIN
  } state_t;

  state_t        state_q;
  logic [TW-1:0] tick_cnt_q;
  logic [TW-1:0] tick_cnt_d;
  logic          tick;
  logic [HW-1:0] half_q;
  logic [4:0]    rise_q;
  logic [15:0]   sr_q;
  logic [15:0]   sr_d;
  logic          cs_q;
  logic          sclk_q;
  logic          dl_q;
  logic [N-1:0]  uk_q;
  logic [N-1:0]  uk_d;

  // Sample-period timebase, free running even while disabled.
  always_comb begin
    tick       = (tick_cnt_q == TW'(SAMPLE_DIV - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  // Offset binary -> two's complement by flipping the MSB,
  // then left-align in the N-bit word.
  always_comb begin
    sr_d             = {sr_q[14:0], bus.sdata};
    uk_d             = '0;
    uk_d[N-1 -: 12]  = {~sr_q[11], sr_q[10:0]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= REPOSO;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b1;
      dl_q    <= 1'b0;
      uk_q    <= '0;
      half_q  <= '0;
      rise_q  <= '0;
      sr_q    <= '0;
    end else begin
      dl_q <= 1'b0;
      unique case (state_q)
        REPOSO: begin
          if (tick && bus.habilitar) begin
            state_q <= CAPTURA;
            cs_q    <= 1'b0;
            sclk_q  <= 1'b1;
            half_q  <= '0;
            rise_q  <= '0;
          end
        end
        CAPTURA: begin
          if (half_q == HW'(SCLK_DIV - 1)) begin
            half_q <= '0;
            sclk_q <= ~sclk_q;
            // low->high edge: take the bit the ADC set up on the fall
            if (!sclk_q) begin
              sr_q   <= sr_d;
              rise_q <= rise_q + 5'd1;
              if (rise_q == 5'd15) begin
                state_q <= FIN;
                cs_q    <= 1'b1;
              end
            end
          end else begin
            half_q <= half_q + HW'(1);
          end
        end
        FIN: begin
          uk_q    <= uk_d;
          dl_q    <= 1'b1;
          state_q <= REPOSO;
        end
        default: begin
          state_q <= REPOSO;
          cs_q    <= 1'b1;
          sclk_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cs        = cs_q;
  assign bus.sclk      = sclk_q;
  assign bus.uk        = uk_q;
  assign bus.datolisto = dl_q;

endmodule

// File: tb/tb_captura_adc.sv
// tb_captura_adc: ADC serial model feeding captura_adc, with a scoreboard
// of expected samples and a monitor checking timing and values.
module tb_captura_adc;

  localparam int N  = 16;
  localparam int SD = 4;
  localparam int SP = 2000;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  captura_adc_if #(.N(N)) bus ();

  captura_adc #(
    .N(N),
    .SCLK_DIV(SD),
    .SAMPLE_DIV(SP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  logic [N-1:0] exp_q[$];
  logic [15:0]  words_q[$];
  logic [15:0]  cur = 16'h0;
  int           idx = -1;
  int           rel_cnt = 0;
  int           n_csfall = 0;
  int           n_dl = 0;

  // Expected sample: signed value of the 12 data bits, scaled to N bits.
  function automatic logic [N-1:0] model(logic [15:0] w);
    int v;
    v = int'(w[11:0]) - 2048;
    return N'(v * (1 << (N - 12)));
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Edges since reset release; ticks land on multiples of SP.
  always @(posedge clk) begin
    if (reset) rel_cnt = 0;
    else rel_cnt++;
  end

  // ADC model: a new word per conversion, a bit per sclk fall.
  always @(negedge bus.cs) begin
    if (!reset) begin
      if (words_q.size() > 0) cur = words_q.pop_front();
      else cur = 16'($urandom);
      exp_q.push_back(model(cur));
      idx = 15;
    end
  end

  always @(negedge bus.sclk) begin
    if (!bus.cs && idx >= 0) begin
      bus.sdata = cur[idx];
      idx--;
    end
  end

  // Monitor
  logic prev_cs   = 1'b1;
  logic prev_sclk = 1'b1;
  logic prev_dl   = 1'b0;
  int   low_cnt   = 0;
  int   sclk_run  = 0;
  int   pulses    = 0;
  int   fall_at   = 0;
  int   last_dl   = 0;
  bit   in_conv   = 1'b0;
  bit   have_last = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      in_conv   = 1'b0;
      have_last = 1'b0;
      sclk_run  = 0;
    end else begin
      if (!bus.habilitar) have_last = 1'b0;
      if (prev_cs && !bus.cs) begin
        n_csfall++;
        chk("cs_phase", rel_cnt % SP, 0);
        fall_at = rel_cnt;
        in_conv = 1'b1;
        low_cnt = 0;
        pulses  = 0;
        sclk_run = 0;
      end
      if (!bus.cs) low_cnt++;
      if (!bus.sclk) begin
        sclk_run++;
      end else if (!prev_sclk) begin
        chk("sclk_low_width", sclk_run, SD);
        pulses++;
        sclk_run = 0;
      end
      if (!prev_cs && bus.cs && in_conv) begin
        chk("cs_low_cycles", low_cnt, 32 * SD);
        chk("sclk_pulses", pulses, 16);
        in_conv = 1'b0;
      end
      if (bus.datolisto) begin
        n_dl++;
        chk("dl_width", prev_dl, 0);
        chk("dl_latency", rel_cnt - fall_at, 32 * SD + 1);
        if (have_last) chk("dl_period", rel_cnt - last_dl, SP);
        last_dl   = rel_cnt;
        have_last = 1'b1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL uk_unexpected: got %0h expected none", bus.uk);
        end else begin
          chk("uk", bus.uk, exp_q.pop_front());
        end
      end
    end
    prev_cs   = bus.cs;
    prev_sclk = bus.sclk;
    prev_dl   = bus.datolisto;
  end

  task automatic wait_cs(int target, int budget);
    int t = 0;
    while (n_csfall < target && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("cs_fall_timeout", n_csfall >= target, 1);
  endtask

  task automatic wait_dl(int target, int budget);
    int t = 0;
    while (n_dl < target && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("dl_timeout", n_dl >= target, 1);
  endtask

  initial begin
    int c0;
    int d0;
    int idle_bad;
    bus.habilitar = 1'b0;
    bus.sdata     = 1'b0;
    words_q = '{16'h1234, 16'h0800, 16'h0000, 16'h0FFF,
                16'hF000, 16'hFFFF, 16'hF800};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs", bus.cs, 1);
    chk("rst_sclk", bus.sclk, 1);
    chk("rst_uk", bus.uk, 0);
    chk("rst_dl", bus.datolisto, 0);

    // Abort the first conversion with a reset 40 cycles in.
    reset = 1'b0;
    bus.habilitar = 1'b1;
    wait_cs(1, SP + 10);
    repeat (39) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_cs", bus.cs, 1);
    chk("abort_sclk", bus.sclk, 1);
    chk("abort_uk", bus.uk, 0);
    chk("abort_dl", bus.datolisto, 0);
    exp_q.delete();
    d0 = n_dl;
    chk("abort_no_dl", d0, 0);
    reset = 1'b0;

    // Directed words then random ones, habilitar held high.
    wait_dl(8, 8 * SP + 400);

    // Disabled across a tick: bus stays idle.
    bus.habilitar = 1'b0;
    c0 = n_csfall;
    d0 = n_dl;
    idle_bad = 0;
    repeat (2 * SP) begin
      @(negedge clk);
      if (bus.cs !== 1'b1 || bus.sclk !== 1'b1) idle_bad++;
    end
    chk("idle_bus", idle_bad, 0);
    chk("idle_no_cs", n_csfall, c0);
    chk("idle_no_dl", n_dl, d0);

    // Drop habilitar mid-conversion: it still completes, once.
    bus.habilitar = 1'b1;
    wait_cs(c0 + 1, SP + 10);
    repeat (20) @(negedge clk);
    bus.habilitar = 1'b0;
    wait_dl(d0 + 1, 200);
    repeat (SP + 200) @(negedge clk);
    chk("drop_single_dl", n_dl, d0 + 1);

    // Back to steady random sampling.
    bus.habilitar = 1'b1;
    wait_dl(d0 + 5, 4 * SP + 400);
    bus.habilitar = 1'b0;

    chk("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
